// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin writeback arbiter for four register-file write ports
module wb_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int NREQ  = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wb_stall,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ*$clog2(DEPTH)-1:0]      req_tag,
  input  logic [NREQ*WIDTH-1:0]              req_data,
  output logic [NREQ-1:0]                    req_ready,
  output logic                               we_1,
  output logic                               we_2,
  output logic                               we_3,
  output logic                               we_4,
  output logic [$clog2(DEPTH)-1:0]           write_reg1,
  output logic [$clog2(DEPTH)-1:0]           write_reg2,
  output logic [$clog2(DEPTH)-1:0]           write_reg3,
  output logic [$clog2(DEPTH)-1:0]           write_reg4,
  output logic [WIDTH-1:0]                   write_reg1_data,
  output logic [WIDTH-1:0]                   write_reg2_data,
  output logic [WIDTH-1:0]                   write_reg3_data,
  output logic [WIDTH-1:0]                   write_reg4_data,
  output logic [15:0]                        wr_count
);

  localparam int TW = $clog2(DEPTH);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_next;
  logic [NREQ-1:0]  ready_c;
  logic [2:0]       n_grant;
  logic             g_val  [4];
  logic [TW-1:0]    g_tag  [4];
  logic [WIDTH-1:0] g_data [4];

  logic             we_q   [4];
  logic [TW-1:0]    reg_q  [4];
  logic [WIDTH-1:0] data_q [4];
  logic [16:0]      cnt_sum;

  // Scan requesters from rr_ptr, drop tag-0 results, hand nonzero tags to free ports skipping duplicates
  always_comb begin
    int            idx;
    logic [TW-1:0] tag;
    logic          conflict;
    ready_c  = '0;
    n_grant  = '0;
    rr_next  = rr_ptr;
    idx      = 0;
    tag      = '0;
    conflict = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g_val[k]  = 1'b0;
      g_tag[k]  = '0;
      g_data[k] = '0;
    end
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      tag = req_tag[idx*TW +: TW];
      if (!rst && !wb_stall && req_valid[idx]) begin
        if (tag == '0) begin
          ready_c[idx] = 1'b1;
        end else if (n_grant < 3'd4) begin
          conflict = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (g_val[k] && g_tag[k] == tag) conflict = 1'b1;
          end
          if (!conflict) begin
            g_val[n_grant[1:0]]  = 1'b1;
            g_tag[n_grant[1:0]]  = tag;
            g_data[n_grant[1:0]] = req_data[idx*WIDTH +: WIDTH];
            ready_c[idx]         = 1'b1;
            rr_next              = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
            n_grant              = n_grant + 3'd1;
          end
        end
      end
    end
  end

  assign req_ready = ready_c;
  assign cnt_sum   = {1'b0, wr_count} + {14'b0, n_grant};

  // Register the granted writes, advance the round-robin pointer and the saturating write count
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      wr_count <= '0;
      for (int k = 0; k < 4; k++) begin
        we_q[k]   <= 1'b0;
        reg_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        we_q[k] <= g_val[k];
        if (g_val[k]) begin
          reg_q[k]  <= g_tag[k];
          data_q[k] <= g_data[k];
        end
      end
      rr_ptr   <= rr_next;
      wr_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign we_1            = we_q[0];
  assign we_2            = we_q[1];
  assign we_3            = we_q[2];
  assign we_4            = we_q[3];
  assign write_reg1      = reg_q[0];
  assign write_reg2      = reg_q[1];
  assign write_reg3      = reg_q[2];
  assign write_reg4      = reg_q[3];
  assign write_reg1_data = data_q[0];
  assign write_reg2_data = data_q[1];
  assign write_reg3_data = data_q[2];
  assign write_reg4_data = data_q[3];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;
  localparam int NREQ  = 6;
  localparam int TW    = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wb_stall;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*TW-1:0]    req_tag;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  we_1, we_2, we_3, we_4;
  logic [TW-1:0]         write_reg1, write_reg2, write_reg3, write_reg4;
  logic [WIDTH-1:0]      write_reg1_data, write_reg2_data, write_reg3_data, write_reg4_data;
  logic [15:0]           wr_count;

  logic [3:0]            we_v;
  logic [TW-1:0]         wreg  [4];
  logic [WIDTH-1:0]      wdata [4];

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .we_1(we_1), .we_2(we_2), .we_3(we_3), .we_4(we_4),
    .write_reg1(write_reg1), .write_reg2(write_reg2), .write_reg3(write_reg3), .write_reg4(write_reg4),
    .write_reg1_data(write_reg1_data), .write_reg2_data(write_reg2_data),
    .write_reg3_data(write_reg3_data), .write_reg4_data(write_reg4_data),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  assign we_v     = {we_4, we_3, we_2, we_1};
  assign wreg[0]  = write_reg1;
  assign wreg[1]  = write_reg2;
  assign wreg[2]  = write_reg3;
  assign wreg[3]  = write_reg4;
  assign wdata[0] = write_reg1_data;
  assign wdata[1] = write_reg2_data;
  assign wdata[2] = write_reg3_data;
  assign wdata[3] = write_reg4_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [WIDTH-1:0] d);
    req_valid[i]           = v;
    req_tag[i*TW +: TW]    = t;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, TW'(i + 1), 32'h55);
    #1;
    checks++; if (req_ready !== 6'b0) begin errors++; $display("FAIL reset_ready: got %b expected %b", req_ready, 6'b0); end
    tick();
    tick();
    checks++; if (req_ready !== 6'b0) begin errors++; $display("FAIL reset_ready2: got %b expected %b", req_ready, 6'b0); end
    checks++; if (we_v !== 4'b0) begin errors++; $display("FAIL reset_we: got %b expected %b", we_v, 4'b0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (wreg[k] !== '0 || wdata[k] !== '0) begin errors++; $display("FAIL reset_port%0d: got %h/%h expected 0/0", k + 1, wreg[k], wdata[k]); end
    end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", wr_count, 16'h0); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected %0d", dut.rr_ptr, 0); end
    req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (we_v !== 4'b0) begin errors++; $display("FAIL idle_we: got %b expected %b", we_v, 4'b0); end
    end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL idle_count: got %h expected %h", wr_count, 16'h0); end
  endtask

  task automatic test_six_requests();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, TW'(i + 1), 32'h100 + i);
    #1;
    checks++; if (req_ready !== 6'b001111) begin errors++; $display("FAIL six_ready0: got %b expected %b", req_ready, 6'b001111); end
    tick();
    for (int i = 0; i < 4; i++) req_valid[i] = 1'b0;
    #1;
    checks++; if (we_v !== 4'b1111) begin errors++; $display("FAIL six_we1: got %b expected %b", we_v, 4'b1111); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (wreg[k] !== TW'(k + 1) || wdata[k] !== 32'h100 + k) begin errors++; $display("FAIL six_port%0d: got %0d/%h expected %0d/%h", k + 1, wreg[k], wdata[k], k + 1, 32'h100 + k); end
    end
    checks++; if (dut.rr_ptr !== 3'd4) begin errors++; $display("FAIL six_ptr: got %0d expected %0d", dut.rr_ptr, 4); end
    checks++; if (req_ready !== 6'b110000) begin errors++; $display("FAIL six_ready1: got %b expected %b", req_ready, 6'b110000); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (we_v !== 4'b0011) begin errors++; $display("FAIL six_we2: got %b expected %b", we_v, 4'b0011); end
    checks++; if (write_reg1 !== 6'd5 || write_reg1_data !== 32'h104) begin errors++; $display("FAIL six_p1b: got %0d/%h expected 5/104", write_reg1, write_reg1_data); end
    checks++; if (write_reg2 !== 6'd6 || write_reg2_data !== 32'h105) begin errors++; $display("FAIL six_p2b: got %0d/%h expected 6/105", write_reg2, write_reg2_data); end
    checks++; if (write_reg3 !== 6'd3) begin errors++; $display("FAIL six_p3hold: got %0d expected 3", write_reg3); end
    checks++; if (wr_count !== 16'd6) begin errors++; $display("FAIL six_count: got %0d expected 6", wr_count); end
    checks++; if (dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL six_ptr2: got %0d expected 0", dut.rr_ptr); end
    tick();
    checks++; if (we_v !== 4'b0) begin errors++; $display("FAIL six_we3: got %b expected %b", we_v, 4'b0); end
  endtask

  task automatic test_conflict();
    set_req(0, 1'b1, 6'd9, 32'hA);
    set_req(1, 1'b1, 6'd9, 32'hB);
    #1;
    checks++; if (req_ready !== 6'b000001) begin errors++; $display("FAIL conf_ready0: got %b expected %b", req_ready, 6'b000001); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (we_v !== 4'b0001 || write_reg1 !== 6'd9 || write_reg1_data !== 32'hA) begin errors++; $display("FAIL conf_port0: got %b/%0d/%h expected 0001/9/a", we_v, write_reg1, write_reg1_data); end
    checks++; if (req_ready !== 6'b000010) begin errors++; $display("FAIL conf_ready1: got %b expected %b", req_ready, 6'b000010); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (we_v !== 4'b0001 || write_reg1 !== 6'd9 || write_reg1_data !== 32'hB) begin errors++; $display("FAIL conf_port1: got %b/%0d/%h expected 0001/9/b", we_v, write_reg1, write_reg1_data); end
    checks++; if (wr_count !== 16'd8) begin errors++; $display("FAIL conf_count: got %0d expected 8", wr_count); end
    checks++; if (dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL conf_ptr: got %0d expected 2", dut.rr_ptr); end
  endtask

  task automatic test_tag_zero();
    set_req(0, 1'b1, 6'd10, 32'hD0);
    set_req(1, 1'b1, 6'd11, 32'hD1);
    set_req(2, 1'b1, 6'd0,  32'hD2);
    set_req(3, 1'b1, 6'd13, 32'hD3);
    set_req(4, 1'b1, 6'd14, 32'hD4);
    #1;
    checks++; if (req_ready !== 6'b011111) begin errors++; $display("FAIL tag0_ready: got %b expected %b", req_ready, 6'b011111); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (we_v !== 4'b1111) begin errors++; $display("FAIL tag0_we: got %b expected %b", we_v, 4'b1111); end
    checks++; if (write_reg1 !== 6'd13 || write_reg2 !== 6'd14 || write_reg3 !== 6'd10 || write_reg4 !== 6'd11) begin
      errors++; $display("FAIL tag0_tags: got %0d,%0d,%0d,%0d expected 13,14,10,11", write_reg1, write_reg2, write_reg3, write_reg4);
    end
    checks++; if (write_reg3_data !== 32'hD0) begin errors++; $display("FAIL tag0_data3: got %h expected %h", write_reg3_data, 32'hD0); end
    checks++; if (wr_count !== 16'd12) begin errors++; $display("FAIL tag0_count: got %0d expected 12", wr_count); end
    checks++; if (dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL tag0_ptr: got %0d expected 2", dut.rr_ptr); end
  endtask

  task automatic test_stall_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, TW'(21 + i), 32'h200 + i);
    wb_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 6'b0) begin errors++; $display("FAIL stall_ready: got %b expected %b", req_ready, 6'b0); end
      tick();
      checks++; if (we_v !== 4'b0 || dut.rr_ptr !== 3'd2) begin errors++; $display("FAIL stall_we_ptr: got %b/%0d expected 0000/2", we_v, dut.rr_ptr); end
    end
    checks++; if (wr_count !== 16'd12) begin errors++; $display("FAIL stall_count: got %0d expected 12", wr_count); end
    wb_stall = 1'b0;
    #1;
    checks++; if (req_ready !== 6'b111100) begin errors++; $display("FAIL unstall_ready: got %b expected %b", req_ready, 6'b111100); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 6'b0) begin errors++; $display("FAIL rst_ready: got %b expected %b", req_ready, 6'b0); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (we_v !== 4'b0 || write_reg1 !== '0 || write_reg1_data !== '0) begin errors++; $display("FAIL rst_out: got %b/%0d/%h expected 0000/0/0", we_v, write_reg1, write_reg1_data); end
    checks++; if (wr_count !== 16'd0 || dut.rr_ptr !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d/%0d expected 0/0", wr_count, dut.rr_ptr); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    set_req(0, 1'b1, 6'd1, 32'h300);
    set_req(1, 1'b1, 6'd2, 32'h301);
    #1;
    checks++; if (req_ready !== 6'b000011) begin errors++; $display("FAIL sat_ready: got %b expected %b", req_ready, 6'b000011); end
    tick();
    exp_cnt = 2;
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL sat_start: got %0d expected 2", wr_count); end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, TW'(i + 1), 32'h300 + i);
    for (int c = 0; c < 17000 && exp_cnt < 32'hFFFE; c++) begin
      tick();
      exp_cnt = exp_cnt + 4;
    end
    checks++; if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h expected %h", wr_count, 16'hFFFE); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (wr_count !== 16'hFFFF || we_v !== 4'b1111) begin errors++; $display("FAIL sat_hold: got %h/%b expected ffff/1111", wr_count, we_v); end
    end
    req_valid = '0;
  endtask

  initial begin
    rst       = 1'b1;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    test_reset();
    test_six_requests();
    test_conflict();
    test_tag_zero();
    test_stall_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
